// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: the FSM state
// encoding and the operand forward-select codes.
package hazard_pkg;

  // Controller states; the encoding is also used by older blocks.
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  // Execute-stage ALU operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding selection for both execute-stage ALU
// operands. The memory stage is younger than writeback, so its result wins.
// Register x0 is hard-wired to zero and is therefore never forwarded.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e
);

  localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};

  function automatic logic [1:0] select_source(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_mem,
    input logic              we_mem,
    input logic [REG_AW-1:0] rd_wb,
    input logic              we_wb
  );
    logic [1:0] sel;
    if (rs == ZERO_REG) begin
      sel = FWD_RF;
    end else if (we_mem && (rd_mem == rs)) begin
      sel = FWD_MEM;
    end else if (we_wb && (rd_wb == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Pick the freshest available value for each operand.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    forward_a_e = select_source(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    forward_b_e = select_source(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stall, flush
// and freeze generation, data-memory wait tracking with a timeout flag, and
// saturating stall/flush cycle counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_access_m,
  input  logic              dmem_ready,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              freeze_em,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO   = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] ZERO_REG    = {REG_AW{1'b0}};

  logic [0:0]        state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              freeze_s;
  logic              load_use_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;

  // reg_write_e is carried for interface completeness; load_e alone marks
  // the instructions whose result arrives too late for forwarding.
  logic unused_s;
  assign unused_s = reg_write_e;

  forward_unit #(
    .REG_AW (REG_AW)
  ) u_forward_unit (
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .forward_a_e (fwd_a_s),
    .forward_b_e (fwd_b_s)
  );

  // Freeze while memory is busy, including the RUN cycle that starts the wait.
  always_comb begin
    freeze_s   = 1'b0;
    load_use_s = 1'b0;
    freeze_s   = !dmem_ready && ((state_r == MEM_WAIT) || mem_access_m);
    load_use_s = load_e && (rd_e != ZERO_REG) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  // Per-stage controls, prioritised reset > freeze > taken branch > load-use.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    freeze_em   = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      forward_a_e = fwd_a_s;
      forward_b_e = fwd_b_s;
      if (freeze_s) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        freeze_em = 1'b1;
        flush_w   = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_f = 1'b0;
      end
    end
  end

  // Memory-wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= WAIT_ZERO;
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_access_m && !dmem_ready) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= WAIT_ZERO;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt_r == TIMEOUT_CNT) begin
            mem_err_r <= 1'b1;
          end
          if (dmem_ready) begin
            state_r <= RUN;
          end else if (wait_cnt_r != TIMEOUT_CNT) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= WAIT_ZERO;
        end
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      if (stall_f && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if ((flush_d || flush_e) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage RISC-V pipeline (fetch, decode, execute, memory, writeback). It drives the per-stage stall, flush and freeze controls, and it selects the forwarding paths for the execute-stage ALU operands. It also tracks multi-cycle data-memory waits with a small state machine, and it keeps saturating counters of stall and flush cycles. Its inputs are the register addresses and control bits already carried by the decode, execute, memory and writeback pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register address width
- CNT_W, 32, width of the performance counters
- MEM_TIMEOUT, 15, maximum number of MEM_WAIT cycles before the error flag is set

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rs1_d, rs2_d  in  REG_AW  source registers of the instruction in decode
- rs1_e, rs2_e, rd_e  in  REG_AW  source and destination registers in execute
- reg_write_e, load_e  in  1  execute instruction writes a register / is a load
- pc_src_e  in  1  branch or jump taken, resolved in execute
- rd_m, rd_w  in  REG_AW  destination registers in memory / writeback
- reg_write_m, reg_write_w  in  1  write enables in memory / writeback
- mem_access_m  in  1  memory-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- forward_a_e, forward_b_e  out  2  operand select: 00 = register file, 01 = writeback result, 10 = memory ALU result
- stall_f, stall_d  out  1  hold the PC and the decode register
- freeze_em  out  1  hold the execute and memory pipeline registers
- flush_d, flush_e, flush_w  out  1  load a bubble into the decode, execute or writeback register
- mem_err  out  1  sticky flag: the memory-wait timeout was exceeded
- stall_cnt, flush_cnt  out  CNT_W  saturating cycle counters

## Operation
- FSM states: RUN and MEM_WAIT. The state resets to RUN.
- RUN to MEM_WAIT when mem_access_m=1 and dmem_ready=0.
- MEM_WAIT to RUN in the cycle dmem_ready=1.
- MEM_WAIT (freeze):
  - stall_f, stall_d and freeze_em are 1.
  - flush_w is 1, so no instruction retires twice.
  - flush_d and flush_e are 0.
- Freeze priority: the freeze is decided combinationally, so it also applies in the RUN cycle that triggers it.
  - A freeze overrides load-use and branch handling.
  - A pending pc_src_e or load-use hazard is acted on in the first unfrozen cycle.
- Load-use hazard: load_e=1, rd_e≠0, and rd_e equals rs1_d or rs2_d.
  - stall_f=1, stall_d=1 and flush_e=1, for exactly one cycle.
- Taken branch: pc_src_e=1 gives flush_d=1 and flush_e=1, with no stall.
  - If a load-use hazard occurs in the same cycle, the branch wins: no stall, and the cycle counts as a flush only.
- Forwarding, operand A (operand B is identical using rs2_e):
  - 10 if reg_write_m=1, rd_m≠0 and rd_m=rs1_e.
  - Otherwise 01 if reg_write_w=1, rd_w≠0 and rd_w=rs1_e.
  - Otherwise 00.
  - Register x0 is never forwarded. The memory stage wins over writeback.
- stall_cnt increments on every cycle with stall_f=1. flush_cnt increments on every cycle with flush_d or flush_e set.
  - Both counters saturate at all-ones and never wrap.
- MEM_WAIT timeout:
  - The wait counter clears on entry to MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_err is set and stays set until rst.
  - The freeze continues after the timeout; the controller never aborts an access.

## Timing
- All stall, flush, freeze and forward outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- The FSM state, wait counter, mem_err and both performance counters are registered.
- Reset values (the cycle after rst=1 is sampled):
  - state is RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0.
- While rst=1:
  - flush_d=1, flush_e=1, flush_w=1.
  - All stall and freeze outputs are 0; forward selects are 00.
  - Counters do not increment.
- A reset in the middle of MEM_WAIT returns to RUN on the next edge, whatever dmem_ready is.
- Load-use stall: exactly 1 cycle. Memory wait: N cycles of freeze for N cycles of dmem_ready=0.

## Structure
- A shared package, hazard_pkg, holds:
  - the FSM state encoding (RUN, MEM_WAIT);
  - the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, forward_unit, provides the purely combinational forwarding selection. It is instantiated once and serves both operands.
- The FSM, hazard detection and counters are written inline in pipeline_hazard_ctrl.

## Test plan
- lw x5 in execute with rs1_d=5 → one cycle of stall_f=1, stall_d=1, flush_e=1; stall_cnt rises 0→1.
- rd_m=7 and rd_w=7 with both write enables set, rs1_e=7 → forward_a_e=10. Change rd_m to 3 → forward_a_e=01. Set rs1_e=0 with rd_m=0 → forward_a_e=00.
- pc_src_e=1 together with a load-use hazard → flush_d=1, flush_e=1, stall_f=0; flush_cnt +1, stall_cnt unchanged.
- mem_access_m=1 with dmem_ready low for 3 cycles → freeze_em=1 and flush_w=1 for 3 cycles, return to RUN on the 4th; stall_cnt +3.
- dmem_ready held low for 20 cycles → mem_err=1 after 15 wait cycles and stays set after dmem_ready rises, until rst.
- Counters preloaded near saturation by forcing stall_f for 2^CNT_W cycles (use CNT_W=4 in the bench) → stall_cnt holds at 15. rst asserted in MEM_WAIT → state RUN and all counters 0 on the next edge.
